// File: rtl/board_input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// board_cond_pkg
//
// Shared constants and helpers for the board input conditioner.
//
// Contents:
//   FRAME_CYCLES_60HZ        pixel clocks in one second of 800x525 @ 60 Hz
//   DEFAULT_DEBOUNCE_CYCLES  default debounce window
//   DEFAULT_POR_CYCLES       default reset stretch after every cause clears
//   DEFAULT_LONG_CYCLES      default long-press hold time (1 s at pixel clock)
//   DEFAULT_HEARTBEAT_CYCLES default heartbeat half-period (1 s)
//   cnt_w(limit)             width of a counter that must hold 0..limit
//
// Configuration macro used by the top: BOARD_LONG_PRESS_RESET_EN
// -----------------------------------------------------------------------------
package board_cond_pkg;

    localparam int FRAME_CYCLES_60HZ        = 800 * 525 * 60;
    localparam int DEFAULT_DEBOUNCE_CYCLES  = 65536;
    localparam int DEFAULT_POR_CYCLES       = 512;
    localparam int DEFAULT_LONG_CYCLES      = FRAME_CYCLES_60HZ;
    localparam int DEFAULT_HEARTBEAT_CYCLES = FRAME_CYCLES_60HZ;

    // Width of a counter that has to represent every value 0..limit.
    // Clamped to 1 so a degenerate limit still yields a legal vector.
    function automatic int cnt_w(input int limit);
        if (limit < 1) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

endpackage : board_cond_pkg

// File: rtl/board_input_conditioner_btn_channel.sv
// -----------------------------------------------------------------------------
// btn_channel
//
// One button channel: 2-flop synchroniser (with optional pin inversion),
// debounce, rising-edge press pulse and long-press hold detection.
//
// Parameters:
//   INVERT           1 = raw pin is active-low
//   DEBOUNCE_CYCLES  consecutive mismatching cycles before the level flips (>=1)
//   LONG_CYCLES      cycles the level must stay high to flag a long press (>=1)
//
// Ports:
//   clk         in   clock
//   rst_n       in   synchronous active-low reset
//   raw         in   asynchronous raw pin
//   level       out  debounced level, active-high
//   press       out  one-cycle pulse on the debounced 0->1 edge
//   long_press  out  one-cycle pulse when level has been high LONG_CYCLES cycles
//
// Used by board_input_conditioner (configuration macro of that block:
// BOARD_LONG_PRESS_RESET_EN; this channel is identical in both builds).
// -----------------------------------------------------------------------------
module btn_channel
    import board_cond_pkg::*;
#(
    parameter bit INVERT          = 1'b0,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic long_press
);

    localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);
    localparam int LP_W = cnt_w(LONG_CYCLES);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_CYCLES);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] db_cnt;
    logic [LP_W-1:0] hold_cnt;
    logic            db_done;

    // The synchronised input has disagreed with the level for the full window.
    assign db_done = (sync2 != level) && (db_cnt == DB_LAST);

    // Synchroniser; the inversion is applied before the first flop so every
    // later stage sees an active-high signal.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw ^ INVERT;
            sync2 <= sync1;
        end
    end

    // Debounce: any cycle of agreement restarts the window, so a glitch
    // shorter than DEBOUNCE_CYCLES never reaches the level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level  <= 1'b0;
            press  <= 1'b0;
            db_cnt <= '0;
        end else begin
            press <= db_done && !level;
            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (db_done) begin
                level  <= ~level;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Long-press hold: saturating at LONG_CYCLES gives exactly one pulse per
    // hold; the counter only returns to 0 once the level drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= level && (hold_cnt == LP_LAST);
            if (!level) begin
                hold_cnt <= '0;
            end else if (hold_cnt != LP_MAX) begin
                hold_cnt <= hold_cnt + LP_W'(1);
            end
        end
    end

endmodule : btn_channel

// File: rtl/board_input_conditioner.sv
// -----------------------------------------------------------------------------
// board_input_conditioner
//
// Conditions raw board inputs for the emulator core: N debounced buttons with
// press and long-press pulses, a stretched core reset gated by PLL lock, and a
// heartbeat square wave for an LED.
//
// Configuration macro: BOARD_LONG_PRESS_RESET_EN
//   defined   - a long press on channel RESET_BTN holds the core in reset from
//               the long-press pulse until that button's level returns to 0,
//               followed by the normal POR stretch.
//   undefined - long presses are reported on btn_long only.
//
// Parameters:
//   NUM_BTN, BTN_INV, DEBOUNCE_CYCLES, LONG_CYCLES, POR_CYCLES, RESET_BTN,
//   HEARTBEAT_CYCLES
//
// Ports:
//   clk         in   pixel clock
//   rst_n       in   synchronous active-low reset
//   pll_locked  in   PLL lock, asynchronous
//   btn_raw     in   raw button pins, asynchronous
//   btn_level   out  debounced levels, active-high
//   btn_press   out  one-cycle pulse per debounced rising edge
//   btn_long    out  one-cycle pulse after LONG_CYCLES of continuous hold
//   sys_rst_n   out  conditioned active-low core reset
//   heartbeat   out  LED square wave, half-period HEARTBEAT_CYCLES
// -----------------------------------------------------------------------------
module board_input_conditioner
    import board_cond_pkg::*;
#(
    parameter int                 NUM_BTN          = 4,
    parameter logic [NUM_BTN-1:0] BTN_INV          = 4'b0001,
    parameter int                 DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
    parameter int                 LONG_CYCLES      = DEFAULT_LONG_CYCLES,
    parameter int                 POR_CYCLES       = DEFAULT_POR_CYCLES,
    parameter int                 RESET_BTN        = 0,
    parameter int                 HEARTBEAT_CYCLES = DEFAULT_HEARTBEAT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_long,
    output logic               sys_rst_n,
    output logic               heartbeat
);

    localparam int POR_W = cnt_w(POR_CYCLES);
    localparam int HB_W  = cnt_w(HEARTBEAT_CYCLES);

    localparam logic [POR_W-1:0] POR_MAX = POR_W'(POR_CYCLES);
    localparam logic [HB_W-1:0]  HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Button channels
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_channel #(
            .INVERT          (BTN_INV[i]),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_channel (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw        (btn_raw[i]),
            .level      (btn_level[i]),
            .press      (btn_press[i]),
            .long_press (btn_long[i])
        );
    end

    // -------------------------------------------------------------------------
    // PLL lock synchroniser
    // -------------------------------------------------------------------------
    logic lock_sync1;
    logic lock_sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_sync1 <= 1'b0;
            lock_sync2 <= 1'b0;
        end else begin
            lock_sync1 <= pll_locked;
            lock_sync2 <= lock_sync1;
        end
    end

    // -------------------------------------------------------------------------
    // Long-press reset cause
    // -------------------------------------------------------------------------
    logic long_cause;

`ifdef BOARD_LONG_PRESS_RESET_EN
    logic long_hold;

    // Remembers that the current hold already produced its long pulse, so the
    // cause persists for the rest of the hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            long_hold <= 1'b0;
        end else if (btn_long[RESET_BTN]) begin
            long_hold <= 1'b1;
        end else if (!btn_level[RESET_BTN]) begin
            long_hold <= 1'b0;
        end
    end

    // The pulse cycle itself counts, so the core reset falls on the next edge.
    assign long_cause = btn_long[RESET_BTN] | (long_hold & btn_level[RESET_BTN]);
`else
    assign long_cause = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // POR stretch. rst_n is handled by the reset branch; the remaining causes
    // clear the counter the same way, so every cause restarts the full stretch.
    // sys_rst_n is registered from the counter value, giving POR_CYCLES+1
    // edges from the last cause edge, but is forced low directly by a cause so
    // a lock drop reaches the core with only the synchroniser delay.
    // -------------------------------------------------------------------------
    logic             por_cause;
    logic [POR_W-1:0] por_cnt;

    assign por_cause = !lock_sync2 || long_cause;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            por_cnt   <= '0;
            sys_rst_n <= 1'b0;
        end else if (por_cause) begin
            por_cnt   <= '0;
            sys_rst_n <= 1'b0;
        end else begin
            if (por_cnt != POR_MAX) begin
                por_cnt <= por_cnt + POR_W'(1);
            end
            sys_rst_n <= (por_cnt == POR_MAX);
        end
    end

    // -------------------------------------------------------------------------
    // Heartbeat: free-running, only rst_n clears it, so the LED keeps blinking
    // while the core is held in reset by lock loss or a long press.
    // -------------------------------------------------------------------------
    logic [HB_W-1:0] hb_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt    <= '0;
            heartbeat <= ~heartbeat;
        end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
        end
    end

endmodule : board_input_conditioner
